// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline stage register with a valid/ready handshake. With
// SKID_EN=1 it holds up to two instructions: entry A drives the outputs and
// entry B is a skid slot. With SKID_EN=0 it holds one. in_ready then depends
// combinationally on out_ready. Squash is synchronous through flush. The
// stage also produces a branch-resolution output and a saturating counter of
// stalled cycles.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   flush                 synchronous squash of every held entry
//   in_valid / in_ready   EX-side handshake
//   ctrl_in .. dst_in     EX payload: control, branch target, zero flag,
//                         ALU result, store data, destination index
//   out_valid / out_ready MEM-side handshake for entry A
//   ctrl_out .. dst_out   entry A payload (ctrl_out forced 0 when invalid)
//   branch_taken          out_valid & Branch & zero
//   stall_cnt             saturating count of out_valid & ~out_ready edges
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int CTRL_W  = 5,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] add_in,
   input  logic              zero_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [DATA_W-1:0] rd2_in,
   input  logic [REG_AW-1:0] dst_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic [DATA_W-1:0] add_out,
   output logic              zero_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] rd2_out,
   output logic [REG_AW-1:0] dst_out,
   output logic              branch_taken,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Entry A drives the outputs and entry B is the skid slot.
   logic [1:0]        count_r;
   logic [CTRL_W-1:0] ctrl_a_r, ctrl_b_r;
   logic [DATA_W-1:0] add_a_r, add_b_r;
   logic              zero_a_r, zero_b_r;
   logic [DATA_W-1:0] alu_a_r, alu_b_r;
   logic [DATA_W-1:0] rd2_a_r, rd2_b_r;
   logic [REG_AW-1:0] dst_a_r, dst_b_r;
   logic [CNT_W-1:0]  stall_cnt_r;

   logic       out_valid_s;
   logic       in_ready_s;
   logic       accept_s;
   logic       pop_s;
   logic [1:0] count_nxt_s;
   logic       load_a_in_s;
   logic       load_a_b_s;
   logic       load_b_s;

   assign out_valid_s = (count_r != 2'd0);
   // The skid variant uses only register state for in_ready, so out_ready
   // never reaches EX combinationally.
   assign in_ready_s  = (SKID_EN != 0) ? (count_r != 2'd2) : (~out_valid_s | out_ready);
   assign accept_s    = in_valid & in_ready_s;
   assign pop_s       = out_valid_s & out_ready;

   // Occupancy next-state and the selection of which entry loads from where.
   always_comb begin
      count_nxt_s = count_r;
      load_a_in_s = 1'b0;
      load_a_b_s  = 1'b0;
      load_b_s    = 1'b0;
      if (SKID_EN != 0) begin
         case (count_r)
            2'd0: begin
               if (accept_s) begin
                  load_a_in_s = 1'b1;
                  count_nxt_s = 2'd1;
               end else begin
                  count_nxt_s = 2'd0;
               end
            end
            2'd1: begin
               if (pop_s && accept_s) begin
                  load_a_in_s = 1'b1;
                  count_nxt_s = 2'd1;
               end else if (pop_s) begin
                  count_nxt_s = 2'd0;
               end else if (accept_s) begin
                  load_b_s    = 1'b1;
                  count_nxt_s = 2'd2;
               end else begin
                  count_nxt_s = 2'd1;
               end
            end
            2'd2: begin
               // in_ready is low here, so a pop only moves B forward into A.
               if (pop_s) begin
                  load_a_b_s  = 1'b1;
                  count_nxt_s = 2'd1;
               end else begin
                  count_nxt_s = 2'd2;
               end
            end
            default: begin
               count_nxt_s = 2'd0;
            end
         endcase
      end else begin
         if (accept_s) begin
            load_a_in_s = 1'b1;
            count_nxt_s = 2'd1;
         end else if (pop_s) begin
            count_nxt_s = 2'd0;
         end else begin
            count_nxt_s = count_r;
         end
      end
   end

   // Entry storage. A flush clears only the control bits, so data outputs
   // keep their last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r  <= 2'd0;
         ctrl_a_r <= '0;  add_a_r <= '0;  zero_a_r <= 1'b0;
         alu_a_r  <= '0;  rd2_a_r <= '0;  dst_a_r  <= '0;
         ctrl_b_r <= '0;  add_b_r <= '0;  zero_b_r <= 1'b0;
         alu_b_r  <= '0;  rd2_b_r <= '0;  dst_b_r  <= '0;
      end else if (flush) begin
         count_r  <= 2'd0;
         ctrl_a_r <= '0;
         ctrl_b_r <= '0;
      end else begin
         count_r <= count_nxt_s;
         if (load_a_in_s) begin
            ctrl_a_r <= ctrl_in;  add_a_r <= add_in;  zero_a_r <= zero_in;
            alu_a_r  <= alu_in;   rd2_a_r <= rd2_in;  dst_a_r  <= dst_in;
         end else if (load_a_b_s) begin
            ctrl_a_r <= ctrl_b_r; add_a_r <= add_b_r; zero_a_r <= zero_b_r;
            alu_a_r  <= alu_b_r;  rd2_a_r <= rd2_b_r; dst_a_r  <= dst_b_r;
         end
         if (load_b_s) begin
            ctrl_b_r <= ctrl_in;  add_b_r <= add_in;  zero_b_r <= zero_in;
            alu_b_r  <= alu_in;   rd2_b_r <= rd2_in;  dst_b_r  <= dst_in;
         end
      end
   end

   // Saturating stall counter. Only reset clears it; a flush leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= '0;
      end else if (out_valid_s && !out_ready && (stall_cnt_r != STALL_MAX)) begin
         stall_cnt_r <= stall_cnt_r + STALL_ONE;
      end
   end

   assign in_ready     = in_ready_s;
   assign out_valid    = out_valid_s;
   assign ctrl_out     = out_valid_s ? ctrl_a_r : {CTRL_W{1'b0}};
   assign add_out      = add_a_r;
   assign zero_out     = zero_a_r;
   assign alu_out      = alu_a_r;
   assign rd2_out      = rd2_a_r;
   assign dst_out      = dst_a_r;
   assign branch_taken = out_valid_s & ctrl_a_r[0] & zero_a_r;
   assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage. Two instances share one stimulus:
// u_skid uses the default skid configuration, and u_single uses SKID_EN=0
// and CNT_W=4. Each phase checks only the instance it targets.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready, zero_in;
   logic [4:0]  ctrl_in, dst_in;
   logic [31:0] add_in, alu_in, rd2_in;

   logic        s_in_ready, s_out_valid, s_zero_out, s_branch_taken;
   logic [4:0]  s_ctrl_out, s_dst_out;
   logic [31:0] s_add_out, s_alu_out, s_rd2_out;
   logic [15:0] s_stall_cnt;

   logic        u_in_ready, u_out_valid, u_zero_out, u_branch_taken;
   logic [4:0]  u_ctrl_out, u_dst_out;
   logic [31:0] u_add_out, u_alu_out, u_rd2_out;
   logic [3:0]  u_stall_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.SKID_EN(1)) u_skid (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .ctrl_in(ctrl_in), .add_in(add_in), .zero_in(zero_in), .alu_in(alu_in),
      .rd2_in(rd2_in), .dst_in(dst_in), .out_valid(s_out_valid), .out_ready(out_ready),
      .ctrl_out(s_ctrl_out), .add_out(s_add_out), .zero_out(s_zero_out),
      .alu_out(s_alu_out), .rd2_out(s_rd2_out), .dst_out(s_dst_out),
      .branch_taken(s_branch_taken), .stall_cnt(s_stall_cnt)
   );

   ex_mem_stage #(.SKID_EN(0), .CNT_W(4)) u_single (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(u_in_ready),
      .ctrl_in(ctrl_in), .add_in(add_in), .zero_in(zero_in), .alu_in(alu_in),
      .rd2_in(rd2_in), .dst_in(dst_in), .out_valid(u_out_valid), .out_ready(out_ready),
      .ctrl_out(u_ctrl_out), .add_out(u_add_out), .zero_out(u_zero_out),
      .alu_out(u_alu_out), .rd2_out(u_rd2_out), .dst_out(u_dst_out),
      .branch_taken(u_branch_taken), .stall_cnt(u_stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are then settled and inputs may change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      ctrl_in = 5'b10000; zero_in = 1'b0; add_in = 32'h0; rd2_in = 32'h0;
      dst_in = 5'd3; alu_in = 32'h11;
      #1;

      // Reset with in_valid high.
      tick(); tick();
      check("rst_out_valid", 32'(s_out_valid), 32'h0);
      check("rst_ctrl_out",  32'(s_ctrl_out),  32'h0);
      check("rst_alu_out",   s_alu_out,        32'h0);
      check("rst_stall_cnt", 32'(s_stall_cnt), 32'h0);
      check("rst_in_ready",  32'(s_in_ready),  32'h1);

      // Release reset. The first beat appears one cycle after it is accepted.
      reset = 1'b0; out_ready = 1'b1;
      tick();
      check("first_valid", 32'(s_out_valid), 32'h1);
      check("first_alu",   s_alu_out,        32'h11);
      check("first_ctrl",  32'(s_ctrl_out),  32'h10);
      check("first_dst",   32'(s_dst_out),   32'h3);

      // Streaming with back-to-back beats.
      for (int i = 1; i <= 4; i++) begin
         alu_in = 32'(i);
         tick();
         check("stream_alu",   s_alu_out,        32'(i));
         check("stream_ready", 32'(s_in_ready),  32'h1);
         check("stream_stall", 32'(s_stall_cnt), 32'h0);
      end
      in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(s_out_valid), 32'h0);
      check("drain_ctrl",  32'(s_ctrl_out),  32'h0);
      check("drain_hold",  s_alu_out,        32'h4);

      // Back-pressure fills both entries.
      out_ready = 1'b0; in_valid = 1'b1; alu_in = 32'hA;
      tick();
      alu_in = 32'hB;
      check("bp_ready1", 32'(s_in_ready), 32'h1);
      tick();
      alu_in = 32'hC;
      check("bp_ready2", 32'(s_in_ready), 32'h0);
      tick();
      check("bp_ready3", 32'(s_in_ready),  32'h0);
      check("bp_stall",  32'(s_stall_cnt), 32'h2);
      check("bp_alu_a",  s_alu_out,        32'hA);
      out_ready = 1'b1;
      tick();
      check("bp_out_b",  s_alu_out,       32'hB);
      check("bp_ready4", 32'(s_in_ready), 32'h1);
      tick();
      check("bp_out_c",  s_alu_out,        32'hC);
      in_valid = 1'b0;
      tick();
      check("bp_empty",  32'(s_out_valid), 32'h0);
      check("bp_stall2", 32'(s_stall_cnt), 32'h2);

      // Flush while full, with a live in_valid beat.
      out_ready = 1'b0; in_valid = 1'b1; alu_in = 32'h21;
      tick();
      alu_in = 32'h22;
      tick();
      check("fl_full", 32'(s_in_ready), 32'h0);
      flush = 1'b1; alu_in = 32'h55;
      tick();
      flush = 1'b0;
      check("fl_valid", 32'(s_out_valid),    32'h0);
      check("fl_ctrl",  32'(s_ctrl_out),     32'h0);
      check("fl_ready", 32'(s_in_ready),     32'h1);
      check("fl_br",    32'(s_branch_taken), 32'h0);
      check("fl_stall", 32'(s_stall_cnt),    32'h4);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("fl_no55", 32'(s_out_valid), 32'h0);

      // Branch resolution.
      in_valid = 1'b1; ctrl_in = 5'b00001; zero_in = 1'b1; add_in = 32'h40;
      tick();
      check("br_taken", 32'(s_branch_taken), 32'h1);
      check("br_add",   s_add_out,           32'h40);
      check("br_zero",  32'(s_zero_out),     32'h1);
      zero_in = 1'b0; add_in = 32'h44;
      tick();
      check("br_not_taken", 32'(s_branch_taken), 32'h0);
      check("br_add2",      s_add_out,           32'h44);
      in_valid = 1'b0;
      tick();
      check("br_idle", 32'(s_branch_taken), 32'h0);

      // Single-entry mode.
      reset = 1'b1;
      tick();
      reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; ctrl_in = 5'b10000; alu_in = 32'h31;
      #1;
      check("se_ready_empty", 32'(u_in_ready), 32'h1);
      tick();
      check("se_valid",      32'(u_out_valid), 32'h1);
      check("se_ready_full", 32'(u_in_ready),  32'h0);
      alu_in = 32'h32;
      tick();
      check("se_hold", u_alu_out, 32'h31);
      out_ready = 1'b1;
      #1;
      check("se_ready_pop", 32'(u_in_ready), 32'h1);
      tick();
      check("se_replace",  u_alu_out,        32'h32);
      check("se_valid2",   32'(u_out_valid), 32'h1);
      check("se_stall1",   32'(u_stall_cnt), 32'h1);

      // Stall counter saturation with CNT_W=4.
      out_ready = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("sat_mid", 32'(u_stall_cnt), 32'd11);
      for (int i = 0; i < 10; i++) tick();
      check("sat_max", 32'(u_stall_cnt), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
